// File: rtl/sumador_nibble_pkg.sv
// sumador_nibble_pkg: shared width and result record for the nibble adder slice.
package sumador_nibble_pkg;
    localparam int NIBBLE_W = 4;
    typedef struct packed {
        logic [NIBBLE_W-1:0] sum;
        logic                carry4;
        logic                overflow;
        logic                zero;
        logic                group_p;
        logic                group_g;
    } nib_res_t;
endpackage

// File: rtl/sumador_nibble_core.sv
// cla_nibble_core: combinational 4-bit carry-lookahead adder with status flags.
//   x_i, y_i : operands
//   cin_i    : carry into bit 0
//   res_o    : {sum, carry4, overflow, zero, group_p, group_g}
module cla_nibble_core
    import sumador_nibble_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x_i,
    input  logic [NIBBLE_W-1:0] y_i,
    input  logic                cin_i,
    output nib_res_t            res_o
);
    logic [NIBBLE_W-1:0] p, g, s;
    logic [NIBBLE_W:0]   c;
    logic                gp, gg;
    assign p = x_i ^ y_i;
    assign g = x_i & y_i;
    // every carry is a flat two-level sum of products of p, g and cin
    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & cin_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
    // group terms are cin-independent so a higher lookahead unit can combine slices
    assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign gp   = &p;
    assign c[4] = gg | (gp & cin_i);
    assign s    = p ^ c[NIBBLE_W-1:0];
    assign res_o = '{sum: s, carry4: c[4], overflow: c[3] ^ c[4], zero: s == '0,
                     group_p: gp, group_g: gg};
endmodule

// File: rtl/sumador_nibble.sv
// sumador_nibble: nibble adder slice with optional output register and valid qualifier.
//   clk, rst_n             : clock (rising edge), async active-low reset
//   in_valid               : operands valid this cycle
//   operandX, operandY     : 4-bit operands
//   carry0                 : carry into bit 0
//   sum, carry4, overflow  : result, carry out, two's-complement overflow
//   zero, group_p, group_g : sum==0 flag, group propagate/generate
//   out_valid              : outputs valid
module sumador_nibble
    import sumador_nibble_pkg::*;
#(
    parameter bit REGISTERED = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [NIBBLE_W-1:0] operandX,
    input  logic [NIBBLE_W-1:0] operandY,
    input  logic                carry0,
    output logic [NIBBLE_W-1:0] sum,
    output logic                carry4,
    output logic                overflow,
    output logic                zero,
    output logic                group_p,
    output logic                group_g,
    output logic                out_valid
);
    nib_res_t res, out_r;
    logic     valid_r;
    cla_nibble_core u_core (
        .x_i   (operandX),
        .y_i   (operandY),
        .cin_i (carry0),
        .res_o (res)
    );
    generate
        if (REGISTERED) begin : g_reg
            nib_res_t res_q, res_d;
            logic     valid_q;
            // the mux keeps unknown operands out of the register while idle
            always_comb res_d = in_valid ? res : res_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_q   <= '0;
                    valid_q <= 1'b0;
                end else begin
                    res_q   <= res_d;
                    valid_q <= in_valid;
                end
            end
            assign out_r   = res_q;
            assign valid_r = valid_q;
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk, rst_n};
            assign out_r   = res;
            assign valid_r = in_valid;
        end
    endgenerate
    assign {sum, carry4, overflow, zero, group_p, group_g} = out_r;
    assign out_valid = valid_r;
endmodule

// File: tb/tb_sumador_nibble.sv
// tb_sumador_nibble: randomized/exhaustive check of both register modes against an arithmetic model.
module tb_sumador_nibble;
    logic       clk = 0, rst_n = 1, in_valid = 0, carry0 = 0;
    logic [3:0] operandX = 0, operandY = 0;
    logic [3:0] sum_r, sum_c;
    logic       c4_r, ov_r, z_r, gp_r, gg_r, ov_vr;
    logic       c4_c, ov_c, z_c, gp_c, gg_c, ov_vc;
    logic [8:0] exp_q;
    logic       ev_q;
    logic       en = 0;
    int         total = 0, bad = 0;
    wire  [8:0] r_word = {sum_r, c4_r, ov_r, z_r, gp_r, gg_r};
    wire  [8:0] c_word = {sum_c, c4_c, ov_c, z_c, gp_c, gg_c};

    always #5 clk = ~clk;

    sumador_nibble #(.REGISTERED(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .operandX(operandX),
        .operandY(operandY), .carry0(carry0), .sum(sum_r), .carry4(c4_r),
        .overflow(ov_r), .zero(z_r), .group_p(gp_r), .group_g(gg_r), .out_valid(ov_vr));

    sumador_nibble #(.REGISTERED(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .operandX(operandX),
        .operandY(operandY), .carry0(carry0), .sum(sum_c), .carry4(c4_c),
        .overflow(ov_c), .zero(z_c), .group_p(gp_c), .group_g(gg_c), .out_valid(ov_vc));

    // {sum, carry4, overflow, zero, group_p, group_g} from plain integer arithmetic
    function automatic logic [8:0] model(logic [3:0] x, logic [3:0] y, logic c);
        int u, s, u0;
        logic [3:0] sm;
        u  = int'(x) + int'(y) + int'(c);
        u0 = int'(x) + int'(y);
        s  = int'($signed(x)) + int'($signed(y)) + int'(c);
        sm = u[3:0];
        return {sm, u > 15, (s > 7) || (s < -8), sm == 4'h0, (x ^ y) == 4'hF, u0 > 15};
    endfunction

    task automatic chk(string name, logic [9:0] got, logic [9:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // one-cycle scoreboard for the registered instance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= '0;
            ev_q  <= 1'b0;
        end else begin
            if (in_valid) exp_q <= model(operandX, operandY, carry0);
            ev_q <= in_valid;
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("reg_stream", {r_word, ov_vr}, {exp_q, ev_q});
            chk("comb_valid", {9'b0, ov_vc}, {9'b0, in_valid});
            if (in_valid) chk("comb_stream", {1'b0, c_word}, {1'b0, model(operandX, operandY, carry0)});
        end
    end

    task automatic drive(logic [3:0] x, logic [3:0] y, logic c, logic v);
        @(posedge clk);
        #2;
        operandX = x; operandY = y; carry0 = c; in_valid = v;
    endtask

    // literal expectation pins both the DUTs and the model
    task automatic dir(string name, logic [3:0] x, logic [3:0] y, logic c, logic [8:0] lit);
        drive(x, y, c, 1'b1);
        #1;
        chk({name, "_comb"}, {1'b0, c_word}, {1'b0, lit});
        chk({name, "_model"}, {1'b0, model(x, y, c)}, {1'b0, lit});
        @(posedge clk);
        #1;
        chk({name, "_reg"}, {r_word, ov_vr}, {lit, 1'b1});
    endtask

    initial begin
        #3 rst_n = 0;
        #1 chk("reset_async", {r_word, ov_vr}, 10'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        en = 1;
        //                    sum   c4 ov z gp gg
        dir("x0y1",  4'h0, 4'h1, 1'b0, {4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        dir("xFy1",  4'hF, 4'h1, 1'b0, {4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
        dir("x7y1",  4'h7, 4'h1, 1'b0, {4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        dir("x8y8",  4'h8, 4'h8, 1'b0, {4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
        dir("xFy0c", 4'hF, 4'h0, 1'b1, {4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
        dir("xFyFc", 4'hF, 4'hF, 1'b1, {4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        dir("x5y3",  4'h5, 4'h3, 1'b0, {4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        // idle with unknown operands: registered outputs hold 5+3
        drive(4'bx, 4'bx, 1'bx, 1'b0);
        @(posedge clk);
        #1 chk("hold", {r_word, ov_vr}, {4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        // reset between edges discards the pending 3+4
        drive(4'h3, 4'h4, 1'b0, 1'b1);
        #2 rst_n = 0;
        #1 chk("reset_mid", {r_word, ov_vr}, 10'b0);
        @(posedge clk);
        #1 chk("reset_held", {r_word, ov_vr}, 10'b0);
        in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1 chk("post_reset_idle", {r_word, ov_vr}, 10'b0);
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            drive(v[8:5], v[4:1], v[0], 1'b1);
        end
        for (int i = 0; i < 40; i++)
            drive(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)),
                  1'($urandom_range(3) != 0));
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
